spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sck half-period; legal range 1..255.
REQ-002 SHALL have parameter WIDTH, default 16, meaning bits per transaction.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a transaction.
REQ-006 SHALL have port tx_data, input, WIDTH, word to transmit.
REQ-007 SHALL have port sck, output, 1, SPI serial clock.
REQ-008 SHALL have port sdo, output, 1, serial data out, MSB first.
REQ-009 SHALL have port sdi, input, 1, serial data in.
REQ-010 SHALL have port nss, output, 1, active-low peripheral select.
REQ-011 SHALL have port busy, output, 1, high while a transaction is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at transaction end.
REQ-013 SHALL have port rx_data, output, WIDTH, word received on sdi.

Function
REQ-014 SHALL implement SPI mode 0: sck idles low, sdo changes only on sck falling edges or at select assertion, and sdi is sampled on sck rising edges.
REQ-015 SHALL use the FSM states IDLE, SETUP, HIGH, LOW, HOLD and DONE.
REQ-016 SHALL accept start only in IDLE: tx_data is latched and the FSM enters SETUP on the next edge.
REQ-017 SHALL ignore start outside IDLE, including during the DONE cycle.
REQ-018 In SETUP, SHALL hold nss=0, sck=0, sdo=tx_data[WIDTH-1], busy=1 for CLK_DIV cycles, then go to HIGH.
REQ-019 On entry to HIGH, SHALL set sck=1, shift sdi into the rx shift register LSB, and hold for CLK_DIV cycles.
REQ-020 On leaving HIGH, SHALL set sck=0 and go to LOW if fewer than WIDTH bits are done, else go to HOLD.
REQ-021 On entry to LOW, SHALL present the next lower bit on sdo and hold for CLK_DIV cycles, then go to HIGH.
REQ-022 In HOLD, SHALL keep nss=0 and sck=0 for CLK_DIV cycles, then go to DONE.
REQ-023 In DONE, SHALL set nss=1, busy=0, done=1 and update rx_data with the full received word, all in the same cycle; the FSM returns to IDLE on the next edge.
REQ-024 SHALL hold nss low for exactly (2*WIDTH+1)*CLK_DIV cycles per transaction, i.e. 66 cycles at the defaults.
REQ-025 SHALL produce exactly WIDTH sck rising edges per transaction, with no glitches; sck, sdo and nss SHALL be driven from registers.
REQ-026 SHALL hold rx_data constant except in the DONE cycle.
REQ-027 SHALL drive sdo=0 in IDLE.
REQ-028 SHALL keep the half-period counter and bit counter wide enough for CLK_DIV=255 and WIDTH without wrap-around; the bit counter SHALL saturate at WIDTH.
REQ-029 When start is held high continuously, SHALL begin back-to-back transactions with exactly one IDLE cycle between them (nss high for 2 cycles including DONE).

Reset
REQ-030 While rst=1, asynchronously and regardless of state, SHALL force: FSM=IDLE, sck=0, nss=1, sdo=0, busy=0, done=0, rx_data=0, counters=0.
REQ-031 When reset is asserted mid-transaction, SHALL abort the transaction without emitting done, and SHALL not update rx_data after reset deasserts.

Structure
REQ-032 SHALL place the FSM state enum and the default WIDTH constant in shared package spi_pkg.
REQ-033 SHALL use one sub-module, spi_clk_div, to generate a half-period tick every CLK_DIV cycles; the tick SHALL be restarted at SETUP entry.

Verification
REQ-034 Reset, then tx_data=16'hA5C3 and start for 1 cycle with CLK_DIV=2 -> sdo bits on sck rising edges are 1010_0101_1100_0011, nss low for 66 cycles, done pulses once.
REQ-035 Loopback sdo->sdi with tx_data=16'h1234 -> rx_data=16'h1234 in the done cycle and held afterwards.
REQ-036 sdi tied to 1 with tx_data=16'h0000 -> rx_data=16'hFFFF and sdo=0 throughout.
REQ-037 start pulsed again 10 cycles into a transaction -> no effect: the transaction still has 16 sck rising edges and exactly one done.
REQ-038 rst asserted at cycle 30 of a transaction -> in the same cycle, nss=1, sck=0, busy=0; no done pulse; rx_data=0.
REQ-039 CLK_DIV=1 with start held high -> two back-to-back transactions of 33-cycle nss-low windows, separated by 2 cycles with nss high.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

    // Default number of bits per transaction.
    localparam int SPI_WIDTH = 16;

    // Width of the half-period counter; wide enough for a divider of 255.
    localparam int SPI_DIV_W = 8;

    // Controller FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } spi_state_e;

    // True for every state in which the peripheral is selected.
    function automatic logic is_selected(input spi_state_e s);
        return (s == SETUP) || (s == HIGH) || (s == LOW) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high on every CLK_DIV-th cycle
// counted from the last restart.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [SPI_DIV_W-1:0] TERM = SPI_DIV_W'(CLK_DIV - 1);

    logic [SPI_DIV_W-1:0] cnt_r;

    // Count clk cycles within a half-period; restart aligns phase to SETUP entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {SPI_DIV_W{1'b0}};
        end else if (restart || (cnt_r == TERM)) begin
            cnt_r <= {SPI_DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(SPI_DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (cnt_r == TERM);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master: shifts WIDTH bits out on sdo (MSB first) while
// sampling sdi on every sck rising edge. All pins come from registers
// loaded with the value that matches the state being entered.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi,
    output logic             nss,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BITS_TOTAL = BW'(WIDTH);

    spi_state_e state_r, state_nx;

    logic             tick_s;
    logic             restart_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_nx;
    logic [WIDTH-1:0] tx_sh_r, tx_sh_nx;
    logic [WIDTH-1:0] rx_sh_r, rx_sh_nx;
    logic [WIDTH-1:0] rx_data_r, rx_data_nx;
    logic             sck_r, sck_nx;
    logic             sdo_r, sdo_nx;
    logic             nss_r, nss_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;

    // Half-period timing restarts exactly when a transaction is accepted.
    assign restart_s = (state_r == IDLE) && start;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                end else begin
                    state_nx = IDLE;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    state_nx = HIGH;
                end else begin
                    state_nx = SETUP;
                end
            end
            HIGH: begin
                if (tick_s) begin
                    if (bit_cnt_r < BITS_TOTAL) begin
                        state_nx = LOW;
                    end else begin
                        state_nx = HOLD;
                    end
                end else begin
                    state_nx = HIGH;
                end
            end
            LOW: begin
                if (tick_s) begin
                    state_nx = HIGH;
                end else begin
                    state_nx = LOW;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_nx = DONE;
                end else begin
                    state_nx = HOLD;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output/datapath values for the state being entered on the next edge.
    always_comb begin
        sck_nx     = (state_nx == HIGH);
        nss_nx     = !is_selected(state_nx);
        busy_nx    = is_selected(state_nx);
        done_nx    = (state_nx == DONE);
        sdo_nx     = sdo_r;
        tx_sh_nx   = tx_sh_r;
        rx_sh_nx   = rx_sh_r;
        bit_cnt_nx = bit_cnt_r;
        rx_data_nx = rx_data_r;

        if ((state_r == IDLE) && (state_nx == SETUP)) begin
            tx_sh_nx   = tx_data;
            sdo_nx     = tx_data[WIDTH-1];
            rx_sh_nx   = {WIDTH{1'b0}};
            bit_cnt_nx = {BW{1'b0}};
        end else if ((state_r == HIGH) && (state_nx == LOW)) begin
            // Falling sck: present the next lower bit.
            tx_sh_nx = {tx_sh_r[WIDTH-2:0], 1'b0};
            sdo_nx   = tx_sh_r[WIDTH-2];
        end else if (state_nx == IDLE) begin
            sdo_nx = 1'b0;
        end else begin
            sdo_nx = sdo_r;
        end

        if ((state_r != HIGH) && (state_nx == HIGH)) begin
            // Rising sck: capture sdi and count the bit (saturating).
            rx_sh_nx = {rx_sh_r[WIDTH-2:0], sdi};
            if (bit_cnt_r < BITS_TOTAL) begin
                bit_cnt_nx = bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end else begin
                bit_cnt_nx = bit_cnt_r;
            end
        end else begin
            rx_sh_nx = rx_sh_nx;
        end

        if ((state_r == HOLD) && (state_nx == DONE)) begin
            rx_data_nx = rx_sh_r;
        end else begin
            rx_data_nx = rx_data_r;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_r     <= 1'b0;
            sdo_r     <= 1'b0;
            nss_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tx_sh_r   <= {WIDTH{1'b0}};
            rx_sh_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            rx_data_r <= {WIDTH{1'b0}};
        end else begin
            sck_r     <= sck_nx;
            sdo_r     <= sdo_nx;
            nss_r     <= nss_nx;
            busy_r    <= busy_nx;
            done_r    <= done_nx;
            tx_sh_r   <= tx_sh_nx;
            rx_sh_r   <= rx_sh_nx;
            bit_cnt_r <= bit_cnt_nx;
            rx_data_r <= rx_data_nx;
        end
    end

    assign sck     = sck_r;
    assign sdo     = sdo_r;
    assign nss     = nss_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;

endmodule
